// File: rtl/flit_buffer_rd_arbiter.sv
// Read-side scheduler for a router input port's flit_buffer: round-robin VC
// selection gated by per-VC downstream credit counters, with sticky error flag.
module flit_buffer_rd_arbiter #(
    parameter int unsigned V = 4,
    parameter int unsigned B = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         arb_en,
    input  logic [V-1:0] vc_not_empty,
    input  logic [V-1:0] ssa_rd,
    input  logic [V-1:0] credit_in,
    output logic         rd_en,
    output logic [V-1:0] vc_num_rd,
    output logic [V-1:0] credit_avail,
    output logic         credit_err
);

    localparam int unsigned CW = $clog2(B + 1);
    localparam int unsigned PW = (V > 1) ? $clog2(V) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(B);

    logic [CW-1:0] cnt_q [V];
    logic [CW-1:0] cnt_d [V];
    logic [PW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;
    logic [V-1:0]  req;
    logic [V-1:0]  grant;
    logic [V-1:0]  consume;
    logic [PW-1:0] idx;
    logic          found;

    // Reset gates requests so nothing is granted while the port is held in reset.
    always_comb begin
        req = '0;
        for (int unsigned v = 0; v < V; v++) begin
            req[v] = vc_not_empty[v] & (cnt_q[v] != '0) & ~ssa_rd[v] & arb_en & reset;
        end
    end

    // Round-robin search starting at ptr_q; the winner's successor becomes the new pointer.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < V; i++) begin
            idx = PW'((32'(ptr_q) + i) % V);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = PW'((32'(idx) + 32'd1) % V);
            end
        end
    end

    assign consume = grant | ssa_rd;

    // Credit bookkeeping; out-of-range updates saturate and raise the sticky error.
    always_comb begin
        err_d = err_q;
        for (int unsigned v = 0; v < V; v++) begin
            cnt_d[v] = cnt_q[v];
            if (consume[v] && !credit_in[v]) begin
                if (cnt_q[v] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] - CW'(1);
                end
            end else if (credit_in[v] && !consume[v]) begin
                if (cnt_q[v] == CNT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned v = 0; v < V; v++) begin
                cnt_q[v] <= CNT_MAX;
            end
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < V; v++) begin
                cnt_q[v] <= cnt_d[v];
            end
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        credit_avail = '0;
        for (int unsigned v = 0; v < V; v++) begin
            credit_avail[v] = (cnt_q[v] != '0);
        end
    end

    assign rd_en      = |grant;
    assign vc_num_rd  = grant;
    assign credit_err = err_q;

endmodule

// File: tb/tb_flit_buffer_rd_arbiter.sv
// Bench for flit_buffer_rd_arbiter: directed scenarios plus random traffic,
// all checked against an integer credit/round-robin reference model.
module tb_flit_buffer_rd_arbiter;

    localparam int NV = 4;
    localparam int NB = 4;

    logic          clk;
    logic          reset_n;
    logic          arb_en;
    logic [NV-1:0] vc_not_empty;
    logic [NV-1:0] ssa_rd;
    logic [NV-1:0] credit_in;
    logic          rd_en;
    logic [NV-1:0] vc_num_rd;
    logic [NV-1:0] credit_avail;
    logic          credit_err;

    int n_vec = 0;
    int n_err = 0;

    int            m_cnt [NV];
    int            m_ptr;
    bit            m_err;
    logic          exp_rd;
    logic [NV-1:0] exp_vc;
    logic [NV-1:0] exp_avail;
    logic          exp_errf;

    flit_buffer_rd_arbiter #(.V(NV), .B(NB)) dut (
        .clk          (clk),
        .reset        (reset_n),
        .arb_en       (arb_en),
        .vc_not_empty (vc_not_empty),
        .ssa_rd       (ssa_rd),
        .credit_in    (credit_in),
        .rd_en        (rd_en),
        .vc_num_rd    (vc_num_rd),
        .credit_avail (credit_avail),
        .credit_err   (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int v = 0; v < NV; v++) m_cnt[v] = NB;
        m_ptr = 0;
        m_err = 0;
    endtask

    // Drive inputs (at falling edge) and compute what the outputs must show this cycle.
    task automatic apply(input logic [NV-1:0] ne, input logic [NV-1:0] ssa,
                         input logic [NV-1:0] cin, input logic en);
        bit found;
        vc_not_empty = ne;
        ssa_rd       = ssa;
        credit_in    = cin;
        arb_en       = en;
        #1;
        exp_vc = '0;
        found  = 0;
        if (reset_n && en) begin
            for (int k = 0; k < NV; k++) begin
                int v;
                v = (m_ptr + k) % NV;
                if (!found && ne[v] && m_cnt[v] > 0 && !ssa[v]) begin
                    exp_vc[v] = 1'b1;
                    found     = 1;
                end
            end
        end
        exp_rd = (exp_vc != '0);
        for (int v = 0; v < NV; v++) exp_avail[v] = (m_cnt[v] > 0);
        exp_errf = m_err;
    endtask

    // Clock the DUT and move the model by the same rules.
    task automatic advance();
        @(posedge clk);
        for (int v = 0; v < NV; v++) begin
            bit c;
            if (exp_vc[v]) m_ptr = (v + 1) % NV;
            c = exp_vc[v] || ssa_rd[v];
            if (c && !credit_in[v]) begin
                if (m_cnt[v] == 0) m_err = 1; else m_cnt[v]--;
            end else if (credit_in[v] && !c) begin
                if (m_cnt[v] == NB) m_err = 1; else m_cnt[v]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        vc_not_empty = '0; ssa_rd = '0; credit_in = '0; arb_en = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        apply(4'b1111, 4'b0000, 4'b0000, 1'b1);
        n_vec++;
        if ({rd_en, vc_num_rd, credit_avail, credit_err} !== {1'b0, 4'b0000, 4'b1111, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got rd=%b vc=%b avail=%b err=%b, want rd=0 vc=0000 avail=1111 err=0",
                     rd_en, vc_num_rd, credit_avail, credit_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_credit_drain();
        int grants = 0;
        for (int c = 0; c < 6; c++) begin
            apply(4'b0001, 4'b0000, 4'b0000, 1'b1);
            n_vec++;
            if ({rd_en, vc_num_rd, credit_avail, credit_err} !== {exp_rd, exp_vc, exp_avail, exp_errf}) begin
                n_err++;
                $display("FAIL drain c%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c, rd_en, vc_num_rd,
                         credit_avail, credit_err, exp_rd, exp_vc, exp_avail, exp_errf);
            end
            if (rd_en && vc_num_rd == 4'b0001) grants++;
            advance();
        end
        n_vec++;
        if (grants !== 4 || credit_avail !== 4'b1110) begin
            n_err++;
            $display("FAIL drain_total: got grants=%0d avail=%b want grants=4 avail=1110", grants, credit_avail);
        end
    endtask

    task automatic test_credit_return();
        logic [NV-1:0] seen [3];
        apply(4'b0001, 4'b0000, 4'b0001, 1'b1); seen[0] = vc_num_rd; advance();
        apply(4'b0001, 4'b0000, 4'b0000, 1'b1); seen[1] = vc_num_rd; advance();
        apply(4'b0001, 4'b0000, 4'b0000, 1'b1); seen[2] = vc_num_rd;
        n_vec++;
        if ({seen[0], seen[1], seen[2], credit_err} !== {4'b0000, 4'b0001, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL credit_return: got %b %b %b err=%b want 0000 0001 0000 err=0",
                     seen[0], seen[1], seen[2], credit_err);
        end
        advance();
    endtask

    task automatic test_round_robin();
        logic [NV-1:0] want [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0010, 4'b0100};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            apply(4'b1111, 4'b0000, 4'b0000, (c != 5));
            n_vec++;
            if (vc_num_rd !== want[c] || rd_en !== (want[c] != 0) || vc_num_rd !== exp_vc) begin
                n_err++;
                $display("FAIL round_robin c%0d: got rd=%b vc=%b want vc=%b model=%b",
                         c, rd_en, vc_num_rd, want[c], exp_vc);
            end
            advance();
        end
    endtask

    task automatic test_ssa_bypass();
        int grants = 0;
        do_reset();
        apply(4'b0011, 4'b0001, 4'b0000, 1'b1);
        n_vec++;
        if (vc_num_rd !== 4'b0010) begin
            n_err++;
            $display("FAIL ssa_grant: got vc=%b want 0010", vc_num_rd);
        end
        advance();
        for (int c = 0; c < 5; c++) begin
            apply(4'b0001, 4'b0000, 4'b0000, 1'b1);
            if (vc_num_rd == 4'b0001) grants++;
            advance();
        end
        n_vec++;
        if (grants !== 3) begin
            n_err++;
            $display("FAIL ssa_vc0_credits: got %0d grants want 3", grants);
        end
        for (int c = 0; c < 5; c++) begin
            apply(4'b0010, 4'b0000, 4'b0000, 1'b1);
            if (vc_num_rd == 4'b0010) grants++;
            advance();
        end
        n_vec++;
        if (grants !== 6) begin
            n_err++;
            $display("FAIL ssa_vc1_credits: got %0d total grants want 6", grants);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        apply(4'b0001, 4'b0000, 4'b0001, 1'b1); advance();
        apply(4'b0000, 4'b0000, 4'b0000, 1'b1);
        n_vec++;
        if (credit_err !== 1'b0) begin
            n_err++;
            $display("FAIL same_vc_grant_credit: got err=%b want 0", credit_err);
        end
        apply(4'b0000, 4'b0000, 4'b0001, 1'b1); advance();
        apply(4'b0000, 4'b0000, 4'b0000, 1'b1);
        n_vec++;
        if (credit_err !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_vc0: got err=%b want 1", credit_err);
        end
        do_reset();
        apply(4'b0000, 4'b0000, 4'b0100, 1'b1); advance();
        apply(4'b0000, 4'b0000, 4'b0000, 1'b1);
        n_vec++;
        if (credit_err !== 1'b1 || credit_avail !== 4'b1111) begin
            n_err++;
            $display("FAIL overflow_vc2: got err=%b avail=%b want err=1 avail=1111", credit_err, credit_avail);
        end
        for (int c = 0; c < 4; c++) begin apply(4'b0000, 4'b0100, 4'b0000, 1'b1); advance(); end
        apply(4'b0000, 4'b0000, 4'b0000, 1'b1);
        n_vec++;
        if (credit_avail !== 4'b1011) begin
            n_err++;
            $display("FAIL vc2_held_at_max: got avail=%b want 1011", credit_avail);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        apply(4'b1111, 4'b0000, 4'b0000, 1'b1); advance();
        apply(4'b1111, 4'b0000, 4'b0000, 1'b1); advance();
        apply(4'b1111, 4'b0000, 4'b0000, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({rd_en, vc_num_rd, credit_avail, credit_err} !== {1'b0, 4'b0000, 4'b1111, 1'b0}) begin
            n_err++;
            $display("FAIL midstream_reset: got rd=%b vc=%b avail=%b err=%b want 0/0000/1111/0",
                     rd_en, vc_num_rd, credit_avail, credit_err);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        apply(4'b0110, 4'b0000, 4'b0000, 1'b1);
        n_vec++;
        if (vc_num_rd !== 4'b0010) begin
            n_err++;
            $display("FAIL after_reset_grant: got vc=%b want 0010", vc_num_rd);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [NV-1:0] ne, ssa, cin;
            int r;
            ne  = NV'($urandom);
            r   = $urandom_range(0, 7);
            ssa = '0;
            if (r < NV) ssa[r] = 1'b1;
            cin = NV'($urandom) & NV'($urandom);
            apply(ne, ssa, cin, ($urandom_range(0, 4) != 0));
            n_vec++;
            if ({rd_en, vc_num_rd, credit_avail, credit_err} !== {exp_rd, exp_vc, exp_avail, exp_errf}) begin
                n_err++;
                $display("FAIL random c%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c, rd_en, vc_num_rd,
                         credit_avail, credit_err, exp_rd, exp_vc, exp_avail, exp_errf);
            end
            advance();
            if (c % 100 == 99) do_reset();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        arb_en = 1'b0; vc_not_empty = '0; ssa_rd = '0; credit_in = '0;
        model_reset();
        test_reset();
        test_credit_drain();
        test_credit_return();
        test_round_robin();
        test_ssa_bypass();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
